// File: rtl/mdu_ctrl.sv
// Sequencing controller between the execute stage and the RV32M multiply/divide datapath.
// Accepts one request, holds operands on the datapath, waits the fixed multiply latency or
// the divider strobe, and returns result/tag/error. Corner cases are resolved locally.
module mdu_ctrl #(
  parameter int unsigned MUL_LAT     = 3,
  parameter int unsigned DIV_TIMEOUT = 40
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic        flush_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [7:0]  req_mode_i,
  input  logic [31:0] req_num1_i,
  input  logic [31:0] req_num2_i,
  input  logic [4:0]  req_rd_i,
  output logic [31:0] mdu_num1_o,
  output logic [31:0] mdu_num2_o,
  output logic [7:0]  mdu_mode_o,
  input  logic [31:0] mdu_ans_i,
  input  logic        mdu_div_ready_i,
  output logic        resp_valid_o,
  input  logic        resp_ready_i,
  output logic [31:0] resp_data_o,
  output logic [4:0]  resp_rd_o,
  output logic [1:0]  resp_error_o,
  output logic        busy_o
);

  localparam int unsigned CntW = $clog2(DIV_TIMEOUT + 1);
  // Counter value seen at the edge that completes the operation (edge k sees k-1).
  localparam logic [CntW-1:0] MulLast = CntW'(MUL_LAT - 1);
  localparam logic [CntW-1:0] DivLast = CntW'(DIV_TIMEOUT - 1);

  localparam logic [1:0] ErrOk      = 2'b00;
  localparam logic [1:0] ErrDivZero = 2'b01;
  localparam logic [1:0] ErrTimeout = 2'b10;
  localparam logic [1:0] ErrIllegal = 2'b11;

  typedef enum logic [1:0] {StIdle, StWait, StDone} state_e;

  state_e         state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [7:0]     mode_q, mode_d;
  logic [31:0]    num1_q, num1_d;
  logic [31:0]    num2_q, num2_d;
  logic [4:0]     rd_q, rd_d;
  logic [31:0]    data_q, data_d;
  logic [1:0]     err_q, err_d;

  logic accept;
  logic req_legal, req_div, req_signed_ovf;
  logic wait_is_mul;

  // Request decode: modes 0x40..0x47, bit 2 selects divide, bit 1 selects remainder.
  always_comb begin
    req_legal      = (req_mode_i[7:3] == 5'b01000);
    req_div        = req_mode_i[2];
    req_signed_ovf = ((req_mode_i == 8'h44) || (req_mode_i == 8'h46)) &&
                     (req_num1_i == 32'h8000_0000) && (req_num2_i == 32'hFFFF_FFFF);
    wait_is_mul    = ~mode_q[2];
  end

  // Handshake and status outputs.
  always_comb begin
    unique case (state_q)
      StIdle:  req_ready_o = ~flush_i;
      StDone:  req_ready_o = resp_ready_i & ~flush_i;
      default: req_ready_o = 1'b0;
    endcase
    accept       = req_valid_i & req_ready_o;
    resp_valid_o = (state_q == StDone);
    busy_o       = (state_q != StIdle);
    mdu_num1_o   = num1_q;
    mdu_num2_o   = num2_q;
    mdu_mode_o   = mode_q;
    resp_data_o  = data_q;
    resp_rd_o    = rd_q;
    resp_error_o = err_q;
  end

  // Next-state logic: flush overrides everything, a new acceptance overrides retirement.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    num1_d  = num1_q;
    num2_d  = num2_q;
    rd_d    = rd_q;
    data_d  = data_q;
    err_d   = err_q;
    if (flush_i) begin
      state_d = StIdle;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        StWait: begin
          if (cnt_q != '1) cnt_d = cnt_q + CntW'(1);
          if (wait_is_mul) begin
            if (cnt_q == MulLast) begin
              data_d  = mdu_ans_i;
              err_d   = ErrOk;
              state_d = StDone;
            end
          end else if ((cnt_q != '0) && mdu_div_ready_i) begin
            // First edge after acceptance ignores a strobe left over from a previous divide.
            data_d  = mdu_ans_i;
            err_d   = ErrOk;
            state_d = StDone;
          end else if (cnt_q >= DivLast) begin
            data_d  = '0;
            err_d   = ErrTimeout;
            state_d = StDone;
          end
        end
        StDone: begin
          if (resp_ready_i) state_d = StIdle;
        end
        default: ;
      endcase
      if (accept) begin
        mode_d = req_mode_i;
        num1_d = req_num1_i;
        num2_d = req_num2_i;
        rd_d   = req_rd_i;
        cnt_d  = '0;
        if (!req_legal) begin
          state_d = StDone;
          data_d  = '0;
          err_d   = ErrIllegal;
        end else if (req_div && (req_num2_i == '0)) begin
          state_d = StDone;
          data_d  = req_mode_i[1] ? req_num1_i : 32'hFFFF_FFFF;
          err_d   = ErrDivZero;
        end else if (req_signed_ovf) begin
          state_d = StDone;
          data_d  = req_mode_i[1] ? 32'h0 : 32'h8000_0000;
          err_d   = ErrOk;
        end else begin
          state_d = StWait;
        end
      end
    end
  end

  // State and datapath-facing registers.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      mode_q  <= '0;
      num1_q  <= '0;
      num2_q  <= '0;
      rd_q    <= '0;
      data_q  <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      num1_q  <= num1_d;
      num2_q  <= num2_d;
      rd_q    <= rd_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed testbench for mdu_ctrl with a behavioural datapath stand-in.
module tb_mdu_ctrl;

  localparam int unsigned MulLat     = 3;
  localparam int unsigned DivTimeout = 40;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        flush = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [7:0]  req_mode = '0;
  logic [31:0] req_num1 = '0;
  logic [31:0] req_num2 = '0;
  logic [4:0]  req_rd = '0;
  logic [31:0] mdu_num1, mdu_num2;
  logic [7:0]  mdu_mode;
  logic [31:0] mdu_ans;
  logic        mdu_div_ready = 1'b0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [31:0] resp_data;
  logic [4:0]  resp_rd;
  logic [1:0]  resp_error;
  logic        busy;
  logic [31:0] div_ans = '0;

  int total = 0;
  int bad = 0;

  // Datapath stand-in: multiplier is a plain product, divider result comes from div_ans.
  assign mdu_ans = mdu_mode[2] ? div_ans : mdu_num1 * mdu_num2;

  always #5 clk = ~clk;

  mdu_ctrl #(
    .MUL_LAT    (MulLat),
    .DIV_TIMEOUT(DivTimeout)
  ) dut (
    .clk_i          (clk),
    .rstn_i         (rstn),
    .flush_i        (flush),
    .req_valid_i    (req_valid),
    .req_ready_o    (req_ready),
    .req_mode_i     (req_mode),
    .req_num1_i     (req_num1),
    .req_num2_i     (req_num2),
    .req_rd_i       (req_rd),
    .mdu_num1_o     (mdu_num1),
    .mdu_num2_o     (mdu_num2),
    .mdu_mode_o     (mdu_mode),
    .mdu_ans_i      (mdu_ans),
    .mdu_div_ready_i(mdu_div_ready),
    .resp_valid_o   (resp_valid),
    .resp_ready_i   (resp_ready),
    .resp_data_o    (resp_data),
    .resp_rd_o      (resp_rd),
    .resp_error_o   (resp_error),
    .busy_o         (busy)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one request for exactly one edge; returns 1 ns after the acceptance edge.
  task automatic send(input logic [7:0] m, input logic [31:0] a, input logic [31:0] b,
                      input logic [4:0] rd);
    req_mode  = m;
    req_num1  = a;
    req_num2  = b;
    req_rd    = rd;
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
  endtask

  task automatic retire();
    resp_ready = 1'b1;
    step();
    resp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    step();
    total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0b want=0", resp_valid); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0b want=0", busy); end
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL reset_req_ready got=%0b want=1", req_ready); end
    total++; if ({mdu_mode, mdu_num1, mdu_num2} !== 72'h0) begin bad++; $display("FAIL reset_mdu got=%h want=0", {mdu_mode, mdu_num1, mdu_num2}); end
    total++; if ({resp_data, resp_rd, resp_error} !== 39'h0) begin bad++; $display("FAIL reset_resp got=%h want=0", {resp_data, resp_rd, resp_error}); end
    rstn = 1'b1;
    step();
  endtask

  task automatic test_mul();
    send(8'h40, 32'd7, 32'd6, 5'd5);
    total++; if ({mdu_mode, mdu_num1, mdu_num2} !== {8'h40, 32'd7, 32'd6}) begin bad++; $display("FAIL mul_operands got=%h", {mdu_mode, mdu_num1, mdu_num2}); end
    total++; if (busy !== 1'b1 || req_ready !== 1'b0) begin bad++; $display("FAIL mul_wait_flags got busy=%0b rdy=%0b want 1/0", busy, req_ready); end
    repeat (MulLat - 1) step();
    total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL mul_early got=%0b want=0", resp_valid); end
    step();
    total++; if (resp_valid !== 1'b1) begin bad++; $display("FAIL mul_latency got=%0b want=1", resp_valid); end
    total++; if ({resp_data, resp_rd, resp_error} !== {32'd42, 5'd5, 2'b00}) begin bad++; $display("FAIL mul_result got=%h/%0d/%b want=2a/5/00", resp_data, resp_rd, resp_error); end
    for (int i = 0; i < 4; i++) begin
      step();
      total++; if ({resp_valid, req_ready, resp_data, resp_rd, resp_error} !== {1'b1, 1'b0, 32'd42, 5'd5, 2'b00}) begin bad++; $display("FAIL mul_hold cyc=%0d got=%h", i, {resp_valid, req_ready, resp_data, resp_rd, resp_error}); end
    end
    resp_ready = 1'b1;
    #1;
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL done_req_ready got=%0b want=1", req_ready); end
    step();
    resp_ready = 1'b0;
    total++; if (resp_valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL mul_retire got valid=%0b busy=%0b want 0/0", resp_valid, busy); end
  endtask

  task automatic test_div_zero();
    mdu_div_ready = 1'b1;
    send(8'h44, 32'd100, 32'd0, 5'd3);
    total++; if ({resp_valid, resp_data, resp_error} !== {1'b1, 32'hFFFF_FFFF, 2'b01}) begin bad++; $display("FAIL div_zero got=%0b/%h/%b want=1/ffffffff/01", resp_valid, resp_data, resp_error); end
    retire();
    send(8'h47, 32'h1234, 32'd0, 5'd4);
    total++; if ({resp_valid, resp_data, resp_rd, resp_error} !== {1'b1, 32'h1234, 5'd4, 2'b01}) begin bad++; $display("FAIL remu_zero got=%0b/%h/%0d/%b want=1/1234/4/01", resp_valid, resp_data, resp_rd, resp_error); end
    retire();
    mdu_div_ready = 1'b0;
  endtask

  task automatic test_special();
    send(8'h44, 32'h8000_0000, 32'hFFFF_FFFF, 5'd6);
    total++; if ({resp_valid, resp_data, resp_error} !== {1'b1, 32'h8000_0000, 2'b00}) begin bad++; $display("FAIL div_ovf got=%0b/%h/%b want=1/80000000/00", resp_valid, resp_data, resp_error); end
    retire();
    send(8'h46, 32'h8000_0000, 32'hFFFF_FFFF, 5'd6);
    total++; if ({resp_valid, resp_data, resp_error} !== {1'b1, 32'h0, 2'b00}) begin bad++; $display("FAIL rem_ovf got=%0b/%h/%b want=1/0/00", resp_valid, resp_data, resp_error); end
    retire();
    send(8'h3F, 32'd9, 32'd9, 5'd2);
    total++; if ({resp_valid, resp_data, resp_error} !== {1'b1, 32'h0, 2'b11}) begin bad++; $display("FAIL illegal got=%0b/%h/%b want=1/0/11", resp_valid, resp_data, resp_error); end
    retire();
  endtask

  task automatic test_div_strobe();
    div_ans = 32'h55;
    mdu_div_ready = 1'b1;
    send(8'h45, 32'd100, 32'd7, 5'd7);
    step();
    mdu_div_ready = 1'b0;
    total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL stale_strobe got=%0b want=0", resp_valid); end
    repeat (8) step();
    total++; if (resp_valid !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL div_waiting got valid=%0b busy=%0b want 0/1", resp_valid, busy); end
    mdu_div_ready = 1'b1;
    step();
    mdu_div_ready = 1'b0;
    total++; if ({resp_valid, resp_data, resp_rd, resp_error} !== {1'b1, 32'h55, 5'd7, 2'b00}) begin bad++; $display("FAIL div_strobe got=%0b/%h/%0d/%b want=1/55/7/00", resp_valid, resp_data, resp_rd, resp_error); end
    retire();
  endtask

  task automatic test_timeout();
    send(8'h44, 32'd100, 32'd7, 5'd8);
    repeat (DivTimeout - 1) step();
    total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL timeout_early got=%0b want=0", resp_valid); end
    step();
    total++; if ({resp_valid, resp_data, resp_error} !== {1'b1, 32'h0, 2'b10}) begin bad++; $display("FAIL timeout got=%0b/%h/%b want=1/0/10", resp_valid, resp_data, resp_error); end
    retire();
  endtask

  task automatic test_back_to_back();
    send(8'h40, 32'd3, 32'd5, 5'd9);
    repeat (MulLat) step();
    total++; if ({resp_valid, resp_data} !== {1'b1, 32'd15}) begin bad++; $display("FAIL b2b_first got=%0b/%h want=1/f", resp_valid, resp_data); end
    req_mode = 8'h44; req_num1 = 32'd9; req_num2 = 32'd0; req_rd = 5'd10;
    req_valid = 1'b1;
    resp_ready = 1'b1;
    step();
    req_valid = 1'b0;
    resp_ready = 1'b0;
    total++; if ({busy, resp_valid, resp_data, resp_rd, resp_error} !== {1'b1, 1'b1, 32'hFFFF_FFFF, 5'd10, 2'b01}) begin bad++; $display("FAIL b2b_second got=%h", {busy, resp_valid, resp_data, resp_rd, resp_error}); end
    total++; if (mdu_num1 !== 32'd9) begin bad++; $display("FAIL b2b_operand got=%h want=9", mdu_num1); end
    retire();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL b2b_idle got=%0b want=0", busy); end
  endtask

  task automatic test_flush();
    send(8'h45, 32'd100, 32'd7, 5'd11);
    repeat (3) step();
    flush = 1'b1;
    #1;
    total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL flush_req_ready got=%0b want=0", req_ready); end
    step();
    flush = 1'b0;
    total++; if (busy !== 1'b0 || resp_valid !== 1'b0) begin bad++; $display("FAIL flush_wait got busy=%0b valid=%0b want 0/0", busy, resp_valid); end
    mdu_div_ready = 1'b1;
    step();
    mdu_div_ready = 1'b0;
    step();
    total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL flush_late_strobe got=%0b want=0", resp_valid); end
    // Flush in DONE discards the result and blocks a concurrent request.
    send(8'h3F, 32'd1, 32'd1, 5'd12);
    req_valid = 1'b1;
    flush = 1'b1;
    step();
    flush = 1'b0;
    req_valid = 1'b0;
    total++; if (busy !== 1'b0 || resp_valid !== 1'b0) begin bad++; $display("FAIL flush_done got busy=%0b valid=%0b want 0/0", busy, resp_valid); end
    // Asynchronous reset mid-WAIT.
    send(8'h45, 32'd100, 32'd7, 5'd13);
    step();
    #2;
    rstn = 1'b0;
    #1;
    total++; if ({busy, resp_valid, mdu_mode} !== {1'b0, 1'b0, 8'h0}) begin bad++; $display("FAIL async_reset got=%h want=0", {busy, resp_valid, mdu_mode}); end
    step();
    rstn = 1'b1;
    mdu_div_ready = 1'b1;
    step();
    mdu_div_ready = 1'b0;
    step();
    total++; if (resp_valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL reset_late_strobe got valid=%0b busy=%0b want 0/0", resp_valid, busy); end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div_zero();
    test_special();
    test_div_strobe();
    test_timeout();
    test_back_to_back();
    test_flush();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
